misr_test_sequencer: RTL and testbench

Bus-initiator companion to the MISR signature peripheral. It buffers a block of test words, then drives the peripheral's re/we/addr/data register port to run one complete compaction job:
- program the coefficients;
- reset the MISR, then enable it;
- stream the words back-to-back;
- stop the MISR and poll its done register;
- read the signature and compare it with a golden value.

It sits between a test-pattern source (valid/ready) and the peripheral's register port.

---
 rtl/misr_test_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_misr_test_sequencer.sv | 533 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/misr_test_sequencer.sv
// misr_test_sequencer
// Bus initiator for the MISR signature peripheral. It buffers a block of
// test words from a valid/ready source, then runs one compaction job over the
// peripheral register port: program coefficients, reset and enable the MISR,
// stream the buffered words back-to-back, stop, poll DONE, read the signature
// and compare it with the golden value supplied at start.
module misr_test_sequencer #(
    parameter int                   NBIT_DATA    = 64,
    parameter int                   NBIT_ADDR    = 64,
    parameter logic [NBIT_ADDR-1:0] START_ADDR   = NBIT_ADDR'(2**25),
    parameter int                   BUF_DEPTH    = 16,
    parameter int                   POLL_TIMEOUT = 256
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               start_i,
    input  logic [$clog2(BUF_DEPTH+1)-1:0]     len_i,
    input  logic [NBIT_DATA-1:0]               coeff_i,
    input  logic [NBIT_DATA-1:0]               golden_i,
    input  logic                               in_valid_i,
    input  logic [NBIT_DATA-1:0]               in_data_i,
    output logic                               in_ready_o,
    output logic                               re_o,
    output logic                               we_o,
    output logic [NBIT_ADDR-1:0]               addr_o,
    output logic [NBIT_DATA-1:0]               data_o,
    input  logic [NBIT_DATA-1:0]               data_i,
    output logic                               busy_o,
    output logic                               done_o,
    output logic                               pass_o,
    output logic                               timeout_o,
    output logic [NBIT_DATA-1:0]               signature_o
);

    localparam int LEN_W  = $clog2(BUF_DEPTH + 1);
    localparam int PTR_W  = $clog2(BUF_DEPTH);
    localparam int POLL_W = $clog2(POLL_TIMEOUT + 1);

    // Peripheral register map, relative to the configured base.
    localparam logic [NBIT_ADDR-1:0] CTRL_ADDR  = START_ADDR;
    localparam logic [NBIT_ADDR-1:0] COEFF_ADDR = START_ADDR + NBIT_ADDR'(64'h40);
    localparam logic [NBIT_ADDR-1:0] SIG_ADDR   = START_ADDR + NBIT_ADDR'(64'h80);
    localparam logic [NBIT_ADDR-1:0] DONE_ADDR  = START_ADDR + NBIT_ADDR'(64'hC0);
    localparam logic [NBIT_ADDR-1:0] IDLE_ADDR  = START_ADDR + NBIT_ADDR'(64'h100);

    // CTRL write values: bit0 enable, bit1 out-of-reset, bit2 done request.
    localparam logic [NBIT_DATA-1:0] CTRL_RESET  = NBIT_DATA'(0);
    localparam logic [NBIT_DATA-1:0] CTRL_ENABLE = NBIT_DATA'(3);
    localparam logic [NBIT_DATA-1:0] CTRL_STOP   = NBIT_DATA'(6);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FILL,
        S_COEFF,
        S_RST,
        S_EN,
        S_STREAM,
        S_STOP,
        S_POLL,
        S_SIG,
        S_DONE
    } state_t;

    state_t                state;
    state_t                state_nx;

    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      len_sat;
    logic [LEN_W-1:0]      wr_cnt;
    logic [LEN_W-1:0]      rd_cnt;
    logic [POLL_W-1:0]     poll_cnt;
    logic [NBIT_DATA-1:0]  coeff_q;
    logic [NBIT_DATA-1:0]  golden_q;
    logic [NBIT_DATA-1:0]  mem [BUF_DEPTH];

    logic                  last_fill;
    logic                  last_stream;
    logic                  last_poll;

    // Requests longer than the buffer are clamped to a full buffer.
    assign len_sat = (len_i > LEN_W'(BUF_DEPTH)) ? LEN_W'(BUF_DEPTH) : len_i;

    assign last_fill   = (wr_cnt == len_q - LEN_W'(1));
    assign last_stream = (rd_cnt == len_q - LEN_W'(1));
    assign last_poll   = (poll_cnt == POLL_W'(POLL_TIMEOUT - 1));

    assign busy_o     = (state != S_IDLE);
    assign done_o     = (state == S_DONE);
    assign in_ready_o = (state == S_FILL);

    // State register; reset forces IDLE regardless of where the job was.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode for the job sequence.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (start_i) begin
                    state_nx = (len_sat != '0) ? S_FILL : S_COEFF;
                end
            end
            S_FILL: begin
                if (in_valid_i && last_fill) begin
                    state_nx = S_COEFF;
                end
            end
            S_COEFF:  state_nx = S_RST;
            S_RST:    state_nx = S_EN;
            S_EN:     state_nx = (len_q == '0) ? S_STOP : S_STREAM;
            S_STREAM: begin
                if (last_stream) begin
                    state_nx = S_STOP;
                end
            end
            S_STOP:   state_nx = S_POLL;
            S_POLL: begin
                if (data_i[0]) begin
                    state_nx = S_SIG;
                end else if (last_poll) begin
                    state_nx = S_DONE;
                end
            end
            S_SIG:    state_nx = S_DONE;
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Moore decode of the register-port access for the current state.
    always_comb begin
        re_o   = 1'b0;
        we_o   = 1'b0;
        addr_o = IDLE_ADDR;
        data_o = '0;
        unique case (state)
            S_COEFF: begin
                we_o   = 1'b1;
                addr_o = COEFF_ADDR;
                data_o = coeff_q;
            end
            S_RST: begin
                we_o   = 1'b1;
                addr_o = CTRL_ADDR;
                data_o = CTRL_RESET;
            end
            S_EN: begin
                we_o   = 1'b1;
                addr_o = CTRL_ADDR;
                data_o = CTRL_ENABLE;
            end
            S_STREAM: begin
                data_o = mem[rd_cnt[PTR_W-1:0]];
            end
            S_STOP: begin
                we_o   = 1'b1;
                addr_o = CTRL_ADDR;
                data_o = CTRL_STOP;
            end
            S_POLL: begin
                re_o   = 1'b1;
                addr_o = DONE_ADDR;
            end
            S_SIG: begin
                re_o   = 1'b1;
                addr_o = SIG_ADDR;
            end
            default: ;
        endcase
    end

    // Job length, buffer/poll counters and the held result flags.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            len_q       <= '0;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            poll_cnt    <= '0;
            pass_o      <= 1'b0;
            timeout_o   <= 1'b0;
            signature_o <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start_i) begin
                        len_q       <= len_sat;
                        wr_cnt      <= '0;
                        rd_cnt      <= '0;
                        pass_o      <= 1'b0;
                        timeout_o   <= 1'b0;
                        signature_o <= '0;
                    end
                end
                S_FILL: begin
                    if (in_valid_i) begin
                        wr_cnt <= wr_cnt + LEN_W'(1);
                    end
                end
                S_STREAM: begin
                    rd_cnt <= rd_cnt + LEN_W'(1);
                end
                S_STOP: begin
                    poll_cnt <= '0;
                end
                S_POLL: begin
                    if (!data_i[0]) begin
                        poll_cnt <= poll_cnt + POLL_W'(1);
                        if (last_poll) begin
                            timeout_o <= 1'b1;
                        end
                    end
                end
                S_SIG: begin
                    signature_o <= data_i;
                    pass_o      <= (data_i == golden_q);
                end
                default: ;
            endcase
        end
    end

    // Job operands and buffered words; plain data, no reset needed.
    always_ff @(posedge clk_i) begin
        if (state == S_IDLE && start_i) begin
            coeff_q  <= coeff_i;
            golden_q <= golden_i;
        end
        if (state == S_FILL && in_valid_i) begin
            mem[wr_cnt[PTR_W-1:0]] <= in_data_i;
        end
    end

endmodule

// File: tb/tb_misr_test_sequencer.sv
// tb_misr_test_sequencer
// Drives misr_test_sequencer against a behavioural MISR peripheral stub and
// compares every cycle of the register-port trace with a reference trace built
// from the job rules.
module tb_misr_test_sequencer;

    localparam int          BD     = 16;
    localparam int          PT     = 4;
    localparam int          LIMIT  = 200;
    localparam logic [63:0] BASE   = 64'h0200_0000;
    localparam logic [63:0] CTRL_A  = BASE;
    localparam logic [63:0] COEFF_A = BASE + 64'h40;
    localparam logic [63:0] SIG_A   = BASE + 64'h80;
    localparam logic [63:0] DONE_A  = BASE + 64'hC0;
    localparam logic [63:0] IDLE_A  = BASE + 64'h100;

    typedef struct packed {
        logic        re;
        logic        we;
        logic        ready;
        logic        busy;
        logic        done;
        logic        pass;
        logic        tmo;
        logic [63:0] addr;
        logic [63:0] data;
        logic [63:0] sig;
    } snap_t;

    logic        clk;
    logic        rst_ni;
    logic        start_i;
    logic [4:0]  len_i;
    logic [63:0] coeff_i;
    logic [63:0] golden_i;
    logic        in_valid_i;
    logic [63:0] in_data_i;
    logic        in_ready_o;
    logic        re_o;
    logic        we_o;
    logic [63:0] addr_o;
    logic [63:0] data_o;
    logic [63:0] data_i;
    logic        busy_o;
    logic        done_o;
    logic        pass_o;
    logic        timeout_o;
    logic [63:0] signature_o;

    int checks = 0;
    int errors = 0;

    logic [63:0] words [0:31];
    logic        vpat  [0:255];
    snap_t       act[$];
    snap_t       exp_q[$];

    // Peripheral stub state
    logic [63:0] p_coeff = '0;
    logic [63:0] p_sig   = '0;
    logic        p_en    = 1'b0;
    logic        p_done  = 1'b0;
    int          p_polls = 0;
    int          done_delay = 0;

    misr_test_sequencer #(
        .NBIT_DATA(64),
        .NBIT_ADDR(64),
        .START_ADDR(BASE),
        .BUF_DEPTH(BD),
        .POLL_TIMEOUT(PT)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_ni),
        .start_i(start_i),
        .len_i(len_i),
        .coeff_i(coeff_i),
        .golden_i(golden_i),
        .in_valid_i(in_valid_i),
        .in_data_i(in_data_i),
        .in_ready_o(in_ready_o),
        .re_o(re_o),
        .we_o(we_o),
        .addr_o(addr_o),
        .data_o(data_o),
        .data_i(data_i),
        .busy_o(busy_o),
        .done_o(done_o),
        .pass_o(pass_o),
        .timeout_o(timeout_o),
        .signature_o(signature_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One MISR step: Galois shift with feedback polynomial, then XOR in the word.
    function automatic logic [63:0] misr_step(logic [63:0] s, logic [63:0] w, logic [63:0] c);
        return {s[62:0], 1'b0} ^ (s[63] ? c : 64'd0) ^ w;
    endfunction

    // Behavioural peripheral: compacts the bus word whenever enabled; the
    // enabling CTRL write itself is compacted, the stopping write is not.
    always @(posedge clk) begin
        if (we_o === 1'b1 && addr_o == CTRL_A) begin
            if (data_o[1] == 1'b0) begin
                p_sig   <= '0;
                p_polls <= 0;
            end else if (data_o[0]) begin
                p_sig <= misr_step(p_sig, data_o, p_coeff);
            end
            p_en   <= data_o[0] & data_o[1];
            p_done <= data_o[2];
        end else if (we_o === 1'b1 && addr_o == COEFF_A) begin
            p_coeff <= data_o;
        end else if (p_en && re_o === 1'b0 && we_o === 1'b0) begin
            p_sig <= misr_step(p_sig, data_o, p_coeff);
        end
        if (re_o === 1'b1 && addr_o == DONE_A) begin
            p_polls <= p_polls + 1;
        end
    end

    always_comb begin
        data_i = 64'hA5A5_5A5A_0F0F_F0F0;
        if (re_o === 1'b1 && addr_o == DONE_A) begin
            data_i = {63'd0, p_done && (p_polls >= done_delay)};
        end else if (re_o === 1'b1 && addr_o == SIG_A) begin
            data_i = p_sig;
        end
    end

    // Reference signature of a job: 0x3 from the enable write, then the words.
    function automatic logic [63:0] misr_of(logic [63:0] c, int n);
        logic [63:0] s;
        s = misr_step(64'd0, 64'd3, c);
        for (int i = 0; i < n; i++) s = misr_step(s, words[i], c);
        return s;
    endfunction

    function automatic snap_t mk(logic re, logic we, logic [63:0] addr, logic [63:0] data, logic ready);
        snap_t s;
        s = '0;
        s.re = re; s.we = we; s.addr = addr; s.data = data; s.ready = ready; s.busy = 1'b1;
        return s;
    endfunction

    // Expected per-cycle trace from cycle 1 through the first IDLE cycle after done.
    function automatic void build_exp(int len_req, logic [63:0] c, logic [63:0] g, int delay);
        int          n;
        int          k;
        int          got;
        logic [63:0] s;
        logic        ok_pass;
        logic        ok_tmo;
        snap_t       e;
        exp_q.delete();
        n = (len_req > BD) ? BD : len_req;
        k = 1;
        got = 0;
        while (got < n) begin
            exp_q.push_back(mk(1'b0, 1'b0, IDLE_A, 64'd0, 1'b1));
            if (vpat[k]) got++;
            k++;
        end
        exp_q.push_back(mk(1'b0, 1'b1, COEFF_A, c, 1'b0));
        exp_q.push_back(mk(1'b0, 1'b1, CTRL_A, 64'd0, 1'b0));
        exp_q.push_back(mk(1'b0, 1'b1, CTRL_A, 64'd3, 1'b0));
        for (int i = 0; i < n; i++) exp_q.push_back(mk(1'b0, 1'b0, IDLE_A, words[i], 1'b0));
        exp_q.push_back(mk(1'b0, 1'b1, CTRL_A, 64'd6, 1'b0));
        s = '0;
        ok_pass = 1'b0;
        ok_tmo = 1'b0;
        if (delay < PT) begin
            for (int i = 0; i <= delay; i++) exp_q.push_back(mk(1'b1, 1'b0, DONE_A, 64'd0, 1'b0));
            exp_q.push_back(mk(1'b1, 1'b0, SIG_A, 64'd0, 1'b0));
            s = misr_of(c, n);
            ok_pass = (s == g);
        end else begin
            for (int i = 0; i < PT; i++) exp_q.push_back(mk(1'b1, 1'b0, DONE_A, 64'd0, 1'b0));
            ok_tmo = 1'b1;
        end
        e = mk(1'b0, 1'b0, IDLE_A, 64'd0, 1'b0);
        e.done = 1'b1; e.pass = ok_pass; e.tmo = ok_tmo; e.sig = s;
        exp_q.push_back(e);
        e.done = 1'b0; e.busy = 1'b0;
        exp_q.push_back(e);
    endfunction

    function automatic snap_t snap();
        snap_t s;
        s.re = re_o; s.we = we_o; s.ready = in_ready_o; s.busy = busy_o; s.done = done_o;
        s.pass = pass_o; s.tmo = timeout_o; s.addr = addr_o; s.data = data_o; s.sig = signature_o;
        return s;
    endfunction

    task automatic set_vpat(input int mode);
        for (int k = 0; k < 256; k++) begin
            if (mode == 0) vpat[k] = 1'b1;
            else if (mode == 1) vpat[k] = k[0];
            else vpat[k] = (k >= 100) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    endtask

    task automatic rand_words();
        for (int i = 0; i < 32; i++) words[i] = {$urandom, $urandom};
    endtask

    // Runs one job: start in cycle 0, source per vpat, optional reset in
    // abort_cyc and optional start pulse in start_cyc; records cycles 1..end.
    task automatic run_job(input int len_req, input logic [63:0] c, input logic [63:0] g,
                           input int abort_cyc, input int start_cyc, output bit expired);
        int widx;
        bit acc;
        bit stop_now;
        act.delete();
        widx = 0;
        stop_now = 0;
        expired = 1;
        @(negedge clk);
        start_i = 1'b1;
        len_i = 5'(len_req);
        coeff_i = c;
        golden_i = g;
        in_valid_i = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= LIMIT; k++) begin
            @(negedge clk);
            act.push_back(snap());
            if (stop_now) begin
                expired = 0;
                break;
            end
            stop_now = (done_o === 1'b1) || (k == abort_cyc);
            start_i = (k == start_cyc);
            rst_ni = (k != abort_cyc);
            in_valid_i = vpat[k];
            in_data_i = words[widx];
            acc = in_valid_i && (in_ready_o === 1'b1);
            @(posedge clk);
            if (acc && widx < 31) widx++;
        end
        rst_ni = 1'b1;
        start_i = 1'b0;
        in_valid_i = 1'b0;
    endtask

    function automatic int done_cycle();
        for (int i = 0; i < act.size(); i++) if (act[i].done === 1'b1) return i + 1;
        return -1;
    endfunction

    task automatic test_reset();
        snap_t e;
        snap_t s;
        e = '0;
        e.addr = IDLE_A;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            s = snap();
            checks++;
            if (s !== e) begin
                errors++;
                $display("FAIL reset_hold cyc %0d got %h exp %h", i, s, e);
            end
        end
        rst_ni = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        s = snap();
        checks++;
        if (s !== e) begin
            errors++;
            $display("FAIL reset_release got %h exp %h", s, e);
        end
    endtask

    task automatic test_nominal();
        bit          expired;
        logic [63:0] g;
        set_vpat(0);
        for (int i = 0; i < 32; i++) words[i] = 64'(i + 1);
        done_delay = 0;
        g = misr_of(64'h1B, 4);
        build_exp(4, 64'h1B, g, 0);
        run_job(4, 64'h1B, g, -1, -1, expired);
        checks++;
        if (expired || act.size() != exp_q.size()) begin
            errors++;
            $display("FAIL nominal_len got %0d exp %0d", act.size(), exp_q.size());
        end
        for (int i = 0; i < act.size() && i < exp_q.size(); i++) begin
            checks++;
            if (act[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL nominal_trace cyc %0d got %h exp %h", i + 1, act[i], exp_q[i]);
            end
        end
        checks++;
        if (done_cycle() != 15) begin
            errors++;
            $display("FAIL nominal_done_cycle got %0d exp 15", done_cycle());
        end
        checks++;
        if (act.size() < 15 || act[14].pass !== 1'b1) begin
            errors++;
            $display("FAIL nominal_pass got %b exp 1", (act.size() < 15) ? 1'bx : act[14].pass);
        end
    endtask

    task automatic test_mismatch();
        bit          expired;
        logic [63:0] g;
        int          dc;
        set_vpat(0);
        for (int i = 0; i < 32; i++) words[i] = 64'(i + 1);
        done_delay = 0;
        g = misr_of(64'h1B, 4) ^ 64'd1;
        build_exp(4, 64'h1B, g, 0);
        run_job(4, 64'h1B, g, -1, -1, expired);
        checks++;
        if (expired || act.size() != exp_q.size()) begin
            errors++;
            $display("FAIL mismatch_len got %0d exp %0d", act.size(), exp_q.size());
        end
        for (int i = 0; i < act.size() && i < exp_q.size(); i++) begin
            checks++;
            if (act[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL mismatch_trace cyc %0d got %h exp %h", i + 1, act[i], exp_q[i]);
            end
        end
        dc = done_cycle();
        checks++;
        if (dc < 1 || act[dc-1].pass !== 1'b0 || act[dc-1].sig !== misr_of(64'h1B, 4)) begin
            errors++;
            $display("FAIL mismatch_result got done_cyc %0d exp pass=0 sig=%h", dc, misr_of(64'h1B, 4));
        end
    endtask

    task automatic test_timeout();
        bit          expired;
        int          n;
        logic [63:0] c;
        int          dc;
        set_vpat(0);
        rand_words();
        n = $urandom_range(1, 6);
        c = {$urandom, $urandom};
        done_delay = 1000;
        build_exp(n, c, 64'd0, 1000);
        run_job(n, c, 64'd0, -1, -1, expired);
        checks++;
        if (expired || act.size() != exp_q.size()) begin
            errors++;
            $display("FAIL timeout_len got %0d exp %0d", act.size(), exp_q.size());
        end
        for (int i = 0; i < act.size() && i < exp_q.size(); i++) begin
            checks++;
            if (act[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL timeout_trace cyc %0d got %h exp %h", i + 1, act[i], exp_q[i]);
            end
        end
        dc = done_cycle();
        checks++;
        if (dc != 2 * n + 5 + PT) begin
            errors++;
            $display("FAIL timeout_done_cycle got %0d exp %0d", dc, 2 * n + 5 + PT);
        end
        checks++;
        if (dc < 1 || act[dc-1].tmo !== 1'b1 || act[dc-1].pass !== 1'b0) begin
            errors++;
            $display("FAIL timeout_flags got done_cyc %0d exp timeout=1 pass=0", dc);
        end
    endtask

    task automatic test_gaps_clamp();
        bit          expired;
        logic [63:0] c;
        logic [63:0] g;
        set_vpat(1);
        rand_words();
        c = {$urandom, $urandom};
        g = misr_of(c, BD);
        done_delay = 1;
        build_exp(20, c, g, 1);
        run_job(20, c, g, -1, -1, expired);
        checks++;
        if (expired || act.size() != exp_q.size()) begin
            errors++;
            $display("FAIL clamp_len got %0d exp %0d", act.size(), exp_q.size());
        end
        for (int i = 0; i < act.size() && i < exp_q.size(); i++) begin
            checks++;
            if (act[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL clamp_trace cyc %0d got %h exp %h", i + 1, act[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_len_zero();
        bit          expired;
        logic [63:0] c;
        set_vpat(0);
        c = {$urandom, $urandom};
        done_delay = 0;
        build_exp(0, c, misr_of(c, 0), 0);
        run_job(0, c, misr_of(c, 0), -1, -1, expired);
        checks++;
        if (expired || act.size() != exp_q.size()) begin
            errors++;
            $display("FAIL len0_len got %0d exp %0d", act.size(), exp_q.size());
        end
        for (int i = 0; i < act.size() && i < exp_q.size(); i++) begin
            checks++;
            if (act[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL len0_trace cyc %0d got %h exp %h", i + 1, act[i], exp_q[i]);
            end
        end
        checks++;
        if (done_cycle() != 7) begin
            errors++;
            $display("FAIL len0_done_cycle got %0d exp 7", done_cycle());
        end
    endtask

    task automatic test_abort_and_ignore();
        bit          expired;
        logic [63:0] c;
        logic [63:0] g;
        snap_t       e;
        // Reset in the second STREAM cycle of a 5-word job.
        set_vpat(0);
        rand_words();
        c = {$urandom, $urandom};
        done_delay = 0;
        build_exp(5, c, misr_of(c, 5), 0);
        while (exp_q.size() > 10) void'(exp_q.pop_back());
        e = '0;
        e.addr = IDLE_A;
        exp_q.push_back(e);
        run_job(5, c, misr_of(c, 5), 10, -1, expired);
        checks++;
        if (expired || act.size() != exp_q.size()) begin
            errors++;
            $display("FAIL abort_len got %0d exp %0d", act.size(), exp_q.size());
        end
        for (int i = 0; i < act.size() && i < exp_q.size(); i++) begin
            checks++;
            if (act[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL abort_trace cyc %0d got %h exp %h", i + 1, act[i], exp_q[i]);
            end
        end
        // Clean job afterwards, with a start pulse in the middle of POLL.
        set_vpat(2);
        rand_words();
        c = {$urandom, $urandom};
        g = misr_of(c, 3);
        done_delay = 2;
        build_exp(3, c, g, 2);
        run_job(3, c, g, -1, (exp_q.size() - 5), expired);
        checks++;
        if (expired || act.size() != exp_q.size()) begin
            errors++;
            $display("FAIL ignore_len got %0d exp %0d", act.size(), exp_q.size());
        end
        for (int i = 0; i < act.size() && i < exp_q.size(); i++) begin
            checks++;
            if (act[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL ignore_trace cyc %0d got %h exp %h", i + 1, act[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit          expired;
        int          n;
        int          dly;
        logic [63:0] c;
        logic [63:0] g;
        for (int j = 0; j < 6; j++) begin
            set_vpat(2);
            rand_words();
            n = $urandom_range(0, 18);
            dly = $urandom_range(0, 5);
            c = {$urandom, $urandom};
            g = ($urandom_range(0, 1) == 1) ? misr_of(c, (n > BD) ? BD : n) : {$urandom, $urandom};
            done_delay = dly;
            build_exp(n, c, g, dly);
            run_job(n, c, g, -1, -1, expired);
            checks++;
            if (expired || act.size() != exp_q.size()) begin
                errors++;
                $display("FAIL b2b_len job %0d got %0d exp %0d", j, act.size(), exp_q.size());
            end
            for (int i = 0; i < act.size() && i < exp_q.size(); i++) begin
                checks++;
                if (act[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL b2b_trace job %0d cyc %0d got %h exp %h", j, i + 1, act[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        start_i = 1'b1;
        len_i = '0;
        coeff_i = '0;
        golden_i = '0;
        in_valid_i = 1'b0;
        in_data_i = '0;
        for (int i = 0; i < 32; i++) words[i] = '0;
        set_vpat(0);
        test_reset();
        test_nominal();
        test_mismatch();
        test_timeout();
        test_gaps_clamp();
        test_len_zero();
        test_abort_and_ignore();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
